// File: rtl/ls_unit.sv
// Load/store sequencer: latches one LDR/STR, runs a ready/valid memory access,
// then drains base and load-data writeback through the single register write port.

module ls_unit_lane #(
  parameter int LANE_W = 2,
  parameter int LANE   = 0
) (
  input  logic              byte_i,
  input  logic [LANE_W-1:0] sel_i,
  input  logic [7:0]        wbyte_i,
  input  logic [7:0]        wword_i,
  input  logic [7:0]        rbyte_i,
  output logic              be_o,
  output logic [7:0]        wdata_o,
  output logic [7:0]        rsel_o
);
  logic hit;
  assign hit     = (sel_i == LANE_W'(LANE));
  assign be_o    = !byte_i || hit;
  assign wdata_o = byte_i ? wbyte_i : wword_i;
  assign rsel_o  = hit ? rbyte_i : 8'h00;
endmodule

module ls_unit #(
  parameter int DATA_W    = 32,
  parameter int OFFSET_W  = 12,
  parameter int REG_IDX_W = 4,
  parameter int BE_W      = DATA_W/8
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_is_store_i,
  input  logic                 req_byte_i,
  input  logic                 req_add_i,
  input  logic                 req_pre_i,
  input  logic                 req_wb_i,
  input  logic [DATA_W-1:0]    req_base_i,
  input  logic [OFFSET_W-1:0]  req_offset_i,
  input  logic [REG_IDX_W-1:0] req_rt_i,
  input  logic [REG_IDX_W-1:0] req_rn_i,
  input  logic [DATA_W-1:0]    req_wdata_i,
  output logic                 mem_req_valid_o,
  input  logic                 mem_req_ready_i,
  output logic                 mem_we_o,
  output logic [DATA_W-1:0]    mem_addr_o,
  output logic [BE_W-1:0]      mem_be_o,
  output logic [DATA_W-1:0]    mem_wdata_o,
  input  logic                 mem_rsp_valid_i,
  input  logic [DATA_W-1:0]    mem_rdata_i,
  output logic                 reg_write_en_o,
  output logic [REG_IDX_W-1:0] reg_write_idx_o,
  output logic [DATA_W-1:0]    reg_write_value_o,
  output logic                 align_err_o
);
  localparam int LANE_W = $clog2(BE_W);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_WB_BASE, S_WB_DATA} state_e;

  typedef struct packed {
    logic                 is_store;
    logic                 is_byte;
    logic                 add;
    logic                 pre;
    logic                 wb;
    logic [DATA_W-1:0]    base;
    logic [OFFSET_W-1:0]  offset;
    logic [REG_IDX_W-1:0] rt;
    logic [REG_IDX_W-1:0] rn;
    logic [DATA_W-1:0]    wdata;
  } req_t;

  function automatic logic [DATA_W-1:0] f_eff(input logic add,
                                               input logic [DATA_W-1:0] base,
                                               input logic [OFFSET_W-1:0] off);
    return add ? base + DATA_W'(off) : base - DATA_W'(off);
  endfunction

  state_e            state_q, state_d;
  req_t              req_q, req_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              align_q, align_d;

  logic [DATA_W-1:0] eff, acc, acc_in;
  logic [LANE_W-1:0] lane;
  logic              wbk;

  assign eff    = f_eff(req_q.add, req_q.base, req_q.offset);
  assign acc    = req_q.pre ? eff : req_q.base;
  assign lane   = acc[LANE_W-1:0];
  assign wbk    = !req_q.pre || req_q.wb;
  // Alignment is judged on the incoming request so the pulse lands on the first REQ cycle.
  assign acc_in = req_pre_i ? f_eff(req_add_i, req_base_i, req_offset_i) : req_base_i;

  logic [BE_W-1:0]        be;
  logic [BE_W-1:0][7:0]   wlane, rsel;
  logic [7:0]             rbyte;

  for (genvar g = 0; g < BE_W; g++) begin : g_lane
    ls_unit_lane #(.LANE_W(LANE_W), .LANE(g)) u_lane (
      .byte_i  (req_q.is_byte),
      .sel_i   (lane),
      .wbyte_i (req_q.wdata[7:0]),
      .wword_i (req_q.wdata[8*g +: 8]),
      .rbyte_i (mem_rdata_i[8*g +: 8]),
      .be_o    (be[g]),
      .wdata_o (wlane[g]),
      .rsel_o  (rsel[g])
    );
  end

  always_comb begin
    rbyte = 8'h00;
    for (int i = 0; i < BE_W; i++) rbyte |= rsel[i];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      req_q   <= '0;
      rdata_q <= '0;
      align_q <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      align_q <= align_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    align_d = 1'b0;
    unique case (state_q)
      S_IDLE: if (req_valid_i) begin
        req_d.is_store = req_is_store_i;
        req_d.is_byte  = req_byte_i;
        req_d.add      = req_add_i;
        req_d.pre      = req_pre_i;
        req_d.wb       = req_wb_i;
        req_d.base     = req_base_i;
        req_d.offset   = req_offset_i;
        req_d.rt       = req_rt_i;
        req_d.rn       = req_rn_i;
        req_d.wdata    = req_wdata_i;
        align_d        = !req_byte_i && (acc_in[LANE_W-1:0] != '0);
        state_d        = S_REQ;
      end
      S_REQ: if (mem_req_ready_i) begin
        if (req_q.is_store) state_d = wbk ? S_WB_BASE : S_IDLE;
        else                state_d = S_WAIT;
      end
      S_WAIT: if (mem_rsp_valid_i) begin
        rdata_d = req_q.is_byte ? DATA_W'(rbyte) : mem_rdata_i;
        state_d = wbk ? S_WB_BASE : S_WB_DATA;
      end
      S_WB_BASE: state_d = req_q.is_store ? S_IDLE : S_WB_DATA;
      S_WB_DATA: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  logic in_req;
  assign in_req = (state_q == S_REQ);

  assign req_ready_o     = (state_q == S_IDLE);
  assign mem_req_valid_o = in_req;
  assign mem_we_o        = in_req && req_q.is_store;
  assign mem_addr_o      = !in_req ? '0
                         : req_q.is_byte ? acc : {acc[DATA_W-1:LANE_W], {LANE_W{1'b0}}};
  assign mem_be_o        = in_req ? be : '0;
  assign mem_wdata_o     = in_req ? wlane : '0;
  assign align_err_o     = align_q;

  always_comb begin
    reg_write_en_o    = 1'b0;
    reg_write_idx_o   = '0;
    reg_write_value_o = '0;
    if (state_q == S_WB_BASE) begin
      reg_write_en_o    = 1'b1;
      reg_write_idx_o   = req_q.rn;
      reg_write_value_o = eff;
    end else if (state_q == S_WB_DATA) begin
      reg_write_en_o    = 1'b1;
      reg_write_idx_o   = req_q.rt;
      reg_write_value_o = rdata_q;
    end
  end
endmodule
